// File: rtl/bubbledrive8_modectrl.sv
// rtl/bubbledrive8_modectrl.sv - BubbleDrive8 power/mode supervisor
module bubbledrive8_modectrl #(
    parameter int DEBOUNCE_CYCLES = 4096,
    parameter int SETTLE_CYCLES   = 64,
    parameter int BLINK_HALF      = 8192
) (
    input  logic       MCLK,
    input  logic       nRST,
    input  logic       PWRSTAT,
    input  logic       MRST,
    output logic       nEMUCOREEN,
    output logic       nTEMPSENSEEN,
    output logic       nFIFOEN,
    output logic       nMPSSEEN,
    output logic       nLEDCTRL_PWROK,
    output logic       nLEDCTRL_STANDBY,
    output logic       nLEDCTRL_DELAYING,
    output logic [2:0] MODE
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_HALF + 1);
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST  = BLK_W'(BLINK_HALF);

    typedef enum logic [2:0] {
        ST_RESET        = 3'b000,
        ST_SELECT       = 3'b001,
        ST_EMU_SETTLE   = 3'b010,
        ST_EMU_RUN      = 3'b011,
        ST_MPSSE_SETTLE = 3'b100,
        ST_MPSSE_RUN    = 3'b101,
        ST_ERR_MB       = 3'b110,
        ST_ERR_USB      = 3'b111
    } state_t;

    state_t state, next_state;

    logic             pwrstat_meta, pwrstat_sync;
    logic             mrst_meta, mrst_sync;
    logic [1:0]       candidate;
    logic [DB_W-1:0]  db_count;
    logic [1:0]       db_pair;
    logic             db_valid;
    logic [SET_W-1:0] settle_count;
    logic [BLK_W-1:0] blink_count;
    logic             blink;
    logic             blinking;
    logic             settling;

    logic             emu_en_next, mpsse_en_next;
    logic             pwrok_next, standby_next, delaying_next;

    wire [1:0] sync_pair = {pwrstat_sync, mrst_sync};

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            pwrstat_meta <= 1'b0;
            pwrstat_sync <= 1'b0;
            mrst_meta    <= 1'b0;
            mrst_sync    <= 1'b0;
        end else begin
            pwrstat_meta <= PWRSTAT;
            pwrstat_sync <= pwrstat_meta;
            mrst_meta    <= MRST;
            mrst_sync    <= mrst_meta;
        end
    end

    // A new pair is accepted only after it has been seen DEBOUNCE_CYCLES times in a row.
    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            candidate <= 2'b01;
            db_count  <= '0;
            db_pair   <= 2'b01;
            db_valid  <= 1'b0;
        end else if (sync_pair != candidate) begin
            candidate <= sync_pair;
            db_count  <= '0;
        end else if (db_count == DB_LAST) begin
            db_pair  <= candidate;
            db_valid <= 1'b1;
        end else begin
            db_count <= db_count + 1'b1;
        end
    end

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state <= ST_RESET;
        end else begin
            state <= next_state;
        end
    end

    assign settling = (state == ST_EMU_SETTLE) || (state == ST_MPSSE_SETTLE);
    assign blinking = (state == ST_MPSSE_RUN) || (state == ST_ERR_MB) || (state == ST_ERR_USB);

    always_comb begin
        next_state = state;
        case (state)
            ST_RESET: begin
                if (db_valid) next_state = ST_SELECT;
            end
            ST_SELECT: begin
                case (db_pair)
                    2'b00:   next_state = ST_EMU_SETTLE;
                    2'b01:   next_state = ST_ERR_MB;
                    2'b10:   next_state = ST_ERR_USB;
                    default: next_state = ST_MPSSE_SETTLE;
                endcase
            end
            ST_EMU_SETTLE: begin
                if (settle_count == SETTLE_LAST) next_state = ST_EMU_RUN;
            end
            ST_EMU_RUN: begin
                if (db_pair[0]) next_state = ST_RESET;
            end
            ST_MPSSE_SETTLE: begin
                if (settle_count == SETTLE_LAST) next_state = ST_MPSSE_RUN;
            end
            ST_MPSSE_RUN: begin
                if (db_pair != 2'b11) next_state = ST_RESET;
            end
            ST_ERR_MB: begin
                if (!db_pair[0]) next_state = ST_RESET;
            end
            ST_ERR_USB: begin
                if (db_pair != 2'b10) next_state = ST_RESET;
            end
            default: next_state = ST_RESET;
        endcase
    end

    // Settle states are only reachable from SELECT, so clearing outside them clears on every entry.
    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            settle_count <= '0;
        end else if (!settling || settle_count == SETTLE_LAST) begin
            settle_count <= '0;
        end else begin
            settle_count <= settle_count + 1'b1;
        end
    end

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            blink       <= 1'b1;
            blink_count <= '0;
        end else if (!blinking) begin
            blink       <= 1'b1;
            blink_count <= '0;
        end else if (blink_count == BLINK_LAST) begin
            blink       <= ~blink;
            blink_count <= '0;
        end else begin
            blink_count <= blink_count + 1'b1;
        end
    end

    always_comb begin
        emu_en_next   = 1'b0;
        mpsse_en_next = 1'b0;
        pwrok_next    = 1'b1;
        standby_next  = 1'b1;
        delaying_next = 1'b1;
        case (state)
            ST_EMU_RUN: begin
                emu_en_next   = 1'b1;
                pwrok_next    = 1'b0;
                delaying_next = 1'b0;
            end
            ST_MPSSE_RUN: begin
                mpsse_en_next = 1'b1;
                pwrok_next    = 1'b0;
                standby_next  = blink;
            end
            ST_ERR_MB, ST_ERR_USB: begin
                pwrok_next = blink;
            end
            default: ;
        endcase
    end

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            nEMUCOREEN        <= 1'b1;
            nTEMPSENSEEN      <= 1'b1;
            nFIFOEN           <= 1'b1;
            nMPSSEEN          <= 1'b1;
            nLEDCTRL_PWROK    <= 1'b1;
            nLEDCTRL_STANDBY  <= 1'b1;
            nLEDCTRL_DELAYING <= 1'b1;
        end else begin
            nEMUCOREEN        <= ~emu_en_next;
            nTEMPSENSEEN      <= ~emu_en_next;
            nFIFOEN           <= ~emu_en_next;
            nMPSSEEN          <= ~mpsse_en_next;
            nLEDCTRL_PWROK    <= pwrok_next;
            nLEDCTRL_STANDBY  <= standby_next;
            nLEDCTRL_DELAYING <= delaying_next;
        end
    end

    assign MODE = state;

endmodule

// File: tb/tb_bubbledrive8_modectrl.sv
// tb/tb_bubbledrive8_modectrl.sv - directed bench for bubbledrive8_modectrl
module tb_bubbledrive8_modectrl;

    logic       MCLK = 1'b0;
    logic       nRST = 1'b0;
    logic       PWRSTAT = 1'b0;
    logic       MRST = 1'b0;
    logic       nEMUCOREEN, nTEMPSENSEEN, nFIFOEN, nMPSSEEN;
    logic       nLEDCTRL_PWROK, nLEDCTRL_STANDBY, nLEDCTRL_DELAYING;
    logic [2:0] MODE;

    int total = 0;
    int bad = 0;

    bubbledrive8_modectrl #(
        .DEBOUNCE_CYCLES(8),
        .SETTLE_CYCLES  (4),
        .BLINK_HALF     (3)
    ) dut (
        .MCLK             (MCLK),
        .nRST             (nRST),
        .PWRSTAT          (PWRSTAT),
        .MRST             (MRST),
        .nEMUCOREEN       (nEMUCOREEN),
        .nTEMPSENSEEN     (nTEMPSENSEEN),
        .nFIFOEN          (nFIFOEN),
        .nMPSSEEN         (nMPSSEEN),
        .nLEDCTRL_PWROK   (nLEDCTRL_PWROK),
        .nLEDCTRL_STANDBY (nLEDCTRL_STANDBY),
        .nLEDCTRL_DELAYING(nLEDCTRL_DELAYING),
        .MODE             (MODE)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic [1:0] pins;
        logic [2:0] mode;
        logic [3:0] en;
        logic       dly;
    } vec_t;

    vec_t vecs[4];

    // Break-before-make watcher: overlap count and shortest all-off gap between core sets.
    int overlap = 0;
    int last_on = 0;
    int all_off = 0;
    int min_gap = 1000000;
    int switches = 0;

    always @(negedge MCLK) begin
        if (!nMPSSEEN && (!nEMUCOREEN || !nTEMPSENSEEN || !nFIFOEN)) begin
            overlap++;
        end
        if (!nEMUCOREEN || !nTEMPSENSEEN || !nFIFOEN) begin
            if (last_on == 1) begin
                switches++;
                if (all_off < min_gap) min_gap = all_off;
            end
            last_on = 2;
            all_off = 0;
        end else if (!nMPSSEEN) begin
            if (last_on == 2) begin
                switches++;
                if (all_off < min_gap) min_gap = all_off;
            end
            last_on = 1;
            all_off = 0;
        end else begin
            all_off++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset(input logic [1:0] pins);
        @(negedge MCLK);
        nRST = 1'b0;
        PWRSTAT = pins[1];
        MRST = pins[0];
        repeat (3) @(negedge MCLK);
        nRST = 1'b1;
    endtask

    task automatic wait_mode(input logic [2:0] m, input int limit, output int cyc);
        cyc = -1;
        for (int c = 0; c <= limit; c++) begin
            if (MODE === m) begin
                cyc = c;
                break;
            end
            @(negedge MCLK);
        end
    endtask

    task automatic count_to_emu(output int lat);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge MCLK);
            if (nEMUCOREEN === 1'b0) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic measure_toggle(input bit use_pwrok, output int g1, output int g2);
        int  t[3];
        int  n;
        logic prev, cur;
        n = 0;
        prev = use_pwrok ? nLEDCTRL_PWROK : nLEDCTRL_STANDBY;
        for (int c = 1; c <= 60 && n < 3; c++) begin
            @(negedge MCLK);
            cur = use_pwrok ? nLEDCTRL_PWROK : nLEDCTRL_STANDBY;
            if (cur !== prev) begin
                t[n] = c;
                n++;
            end
            prev = cur;
        end
        g1 = (n >= 2) ? t[1] - t[0] : -1;
        g2 = (n >= 3) ? t[2] - t[1] : -1;
    endtask

    initial begin
        int lat, cyc, g1, g2, n, stay;
        logic [11:0] path;
        logic [2:0]  last;

        vecs[0] = '{2'b00, 3'b011, 4'b0001, 1'b0};
        vecs[1] = '{2'b01, 3'b110, 4'b1111, 1'b1};
        vecs[2] = '{2'b10, 3'b111, 4'b1111, 1'b1};
        vecs[3] = '{2'b11, 3'b101, 4'b1110, 1'b1};

        repeat (2) @(negedge MCLK);
        check("reset_mode", MODE, 3'b000);
        check("reset_outputs", {nEMUCOREEN, nTEMPSENSEEN, nFIFOEN, nMPSSEEN,
              nLEDCTRL_PWROK, nLEDCTRL_STANDBY, nLEDCTRL_DELAYING}, 7'h7f);

        for (int i = 0; i < 4; i++) begin
            do_reset(vecs[i].pins);
            repeat (40) @(negedge MCLK);
            check($sformatf("vec%0d_mode", i), MODE, vecs[i].mode);
            check($sformatf("vec%0d_enables", i),
                  {nEMUCOREEN, nTEMPSENSEEN, nFIFOEN, nMPSSEEN}, vecs[i].en);
            check($sformatf("vec%0d_delaying", i), nLEDCTRL_DELAYING, vecs[i].dly);
        end

        do_reset(2'b00);
        count_to_emu(lat);
        check_range("cold_boot_latency", lat, 16, 18);
        check("cold_boot_pwrok", nLEDCTRL_PWROK, 1'b0);
        check("cold_boot_mode", MODE, 3'b011);
        check("cold_boot_mpsse_off", nMPSSEEN, 1'b1);

        do_reset(2'b11);
        wait_mode(3'b101, 60, cyc);
        check("mpsse_reached", (cyc >= 0), 1'b1);
        @(negedge MCLK);
        check("mpsse_enables", {nEMUCOREEN, nTEMPSENSEEN, nFIFOEN, nMPSSEEN}, 4'b1110);
        check("mpsse_pwrok", nLEDCTRL_PWROK, 1'b0);
        measure_toggle(1'b0, g1, g2);
        check("standby_half1", g1, 4);
        check("standby_half2", g2, 4);

        MRST = 1'b0;
        path = 12'(MODE);
        last = MODE;
        n = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge MCLK);
            if (MODE !== last) begin
                path = {path[8:0], MODE};
                last = MODE;
                n++;
            end
            if (MODE === 3'b111) break;
        end
        check("err_usb_path_len", n, 4);
        check("err_usb_path", path, 12'b101_000_001_111);
        repeat (2) @(negedge MCLK);
        check("err_usb_enables", {nEMUCOREEN, nTEMPSENSEEN, nFIFOEN, nMPSSEEN}, 4'b1111);
        measure_toggle(1'b1, g1, g2);
        check("err_usb_pwrok_half1", g1, 4);
        check("err_usb_pwrok_half2", g2, 4);

        MRST = 1'b1;
        wait_mode(3'b101, 60, cyc);
        check("back_to_mpsse", (cyc >= 0), 1'b1);
        repeat (3) @(negedge MCLK);
        PWRSTAT = 1'b0;
        wait_mode(3'b110, 60, cyc);
        check("err_mb_reached", (cyc >= 0), 1'b1);
        repeat (3) @(negedge MCLK);
        MRST = 1'b0;
        wait_mode(3'b011, 60, cyc);
        check("mb_to_emu_reached", (cyc >= 0), 1'b1);
        @(negedge MCLK);
        check("mb_to_emu_enables", {nEMUCOREEN, nTEMPSENSEEN, nFIFOEN, nMPSSEEN}, 4'b0001);

        MRST = 1'b1;
        repeat (5) @(negedge MCLK);
        MRST = 1'b0;
        stay = 1;
        for (int c = 0; c < 25; c++) begin
            @(negedge MCLK);
            if (MODE !== 3'b011) stay = 0;
        end
        check("glitch_ignored", stay, 1);
        MRST = 1'b1;
        wait_mode(3'b000, 40, cyc);
        check_range("mrst_exit_latency", cyc, 11, 13);
        @(negedge MCLK);
        check("mrst_exit_enables", {nEMUCOREEN, nTEMPSENSEEN, nFIFOEN, nMPSSEEN}, 4'b1111);

        do_reset(2'b00);
        wait_mode(3'b010, 60, cyc);
        check("emu_settle_reached", (cyc >= 0), 1'b1);
        repeat (2) @(negedge MCLK);
        #2 nRST = 1'b0;
        #1;
        check("midsettle_reset_mode", MODE, 3'b000);
        check("midsettle_reset_outputs", {nEMUCOREEN, nTEMPSENSEEN, nFIFOEN, nMPSSEEN,
              nLEDCTRL_PWROK, nLEDCTRL_STANDBY, nLEDCTRL_DELAYING}, 7'h7f);
        @(negedge MCLK);
        nRST = 1'b1;
        count_to_emu(lat);
        check_range("reboot_latency", lat, 16, 18);

        check("no_overlap", overlap, 0);
        check("core_switch_seen", (switches >= 1), 1'b1);
        check("min_gap_ok", (min_gap >= 4), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bubbledrive8_modectrl.md
Name: bubbledrive8_modectrl

Overview:
- Power/mode supervisor for BubbleDrive8. Sits in the top level between the board-status pins (PWRSTAT, MRST) and the three cores: emucore, tempsense and usb (FIFO/MPSSE).
- Synchronizes and debounces the status pins, then selects emulator, MPSSE-standby or one of two error modes.
- Sequences the active-low core enables break-before-make, with a settle gap between them.
- Drives the PWROK/STANDBY LED controls, including the blinker.

Parameters:
- DEBOUNCE_CYCLES, 4096: consecutive identical synchronized samples needed to accept a new {PWRSTAT,MRST} value (min 2).
- SETTLE_CYCLES, 64: cycles with every core disabled before a new core set is enabled (min 1).
- BLINK_HALF, 8192: blinker half-period is BLINK_HALF+1 MCLK cycles.

Ports:
- MCLK  in  1  48 MHz system clock.
- nRST  in  1  Asynchronous active-low reset.
- PWRSTAT  in  1  Power mux status (0 = motherboard, 1 = USB); asynchronous.
- MRST  in  1  PCB power status (0 = board power good); asynchronous.
- nEMUCOREEN  out  1  emucore enable, active low.
- nTEMPSENSEEN  out  1  tempsense enable, active low.
- nFIFOEN  out  1  usb FIFO enable, active low.
- nMPSSEEN  out  1  usb MPSSE enable, active low.
- nLEDCTRL_PWROK  out  1  PWROK LED drive, active low.
- nLEDCTRL_STANDBY  out  1  STANDBY LED drive, active low.
- nLEDCTRL_DELAYING  out  1  Gate for the tempsense DELAYING LED, active low.
- MODE  out  3  Current state encoding, for debug.

Behaviour:
- Reset (async assert, sync deassert): all enables and LED outputs = 1, MODE = RESET, counters = 0, db_valid = 0.
- Input path: 2-flop synchronizer on each of PWRSTAT and MRST. Candidate register plus counter:
  - sync pair != candidate: candidate <= sync, count <= 0.
  - else if count == DEBOUNCE_CYCLES-1: db_pair <= candidate, db_valid <= 1.
  - else count++.
  - db_pair resets to 2'b01.
- States (MODE encoding in brackets). Every transition is registered, one per cycle.
  - RESET [000]: all disabled. Move to SELECT when db_valid = 1.
  - SELECT [001]: decode db_pair as {PWRSTAT,MRST}: 00 -> EMU_SETTLE, 01 -> ERR_MB, 10 -> ERR_USB, 11 -> MPSSE_SETTLE.
  - EMU_SETTLE [010]: all disabled. settle counter runs 0..SETTLE_CYCLES-1, then EMU_RUN.
  - EMU_RUN [011]:
    - nEMUCOREEN = nTEMPSENSEEN = nFIFOEN = 0, nMPSSEEN = 1.
    - Exit to RESET only when db MRST = 1; PWRSTAT changes are ignored here.
  - MPSSE_SETTLE [100]: all disabled, settle count as above, then MPSSE_RUN.
  - MPSSE_RUN [101]: nMPSSEEN = 0, others = 1. Any db_pair != 11 -> RESET.
  - ERR_MB [110]: all disabled. db MRST = 0 -> RESET.
  - ERR_USB [111]: all disabled. db_pair != 10 -> RESET.
- Enables are a registered decode of the state, so each output changes exactly 1 cycle after the state changes.
- Break-before-make: no cycle ever has nMPSSEEN = 0 together with any of the other three enables = 0. Any path between EMU_RUN and MPSSE_RUN passes through RESET plus a SETTLE state, giving at least SETTLE_CYCLES all-disabled cycles.
- Settle counter clears on every SETTLE entry.
- Blinker:
  - Runs only in MPSSE_RUN, ERR_MB and ERR_USB. Elsewhere blink = 1 and the counter is 0.
  - While running, the counter counts 0..BLINK_HALF, toggles blink on reaching BLINK_HALF, then clears.
  - Entering a blinking state starts from blink = 1, count = 0.
- LED outputs:
  - nLEDCTRL_PWROK = 0 in EMU_RUN and MPSSE_RUN; = blink in the error states; 1 otherwise.
  - nLEDCTRL_STANDBY = blink in MPSSE_RUN, 1 otherwise.
  - nLEDCTRL_DELAYING = 0 in EMU_RUN only.
- Input changes during a SETTLE state are not re-decoded until after the RUN state is reached.
- A glitch shorter than DEBOUNCE_CYCLES never changes db_pair.
- nRST asserted in any state returns all outputs to reset values immediately.

Test Plan (DEBOUNCE_CYCLES=8, SETTLE_CYCLES=4, BLINK_HALF=3):
- Cold boot, pins 00:
  - nEMUCOREEN/nTEMPSENSEEN/nFIFOEN fall to 0 and nMPSSEEN stays 1.
  - Timing: 2 sync + 8 debounce + 1 SELECT + 4 settle + 2 register cycles, ±1, after nRST deassert.
  - nLEDCTRL_PWROK = 0, MODE = 011.
- Boot with 11: nMPSSEEN = 0 and the others 1. nLEDCTRL_STANDBY toggles every 4 cycles; nLEDCTRL_PWROK = 0.
- In MPSSE_RUN, drive MRST 1->0 (pair 10) stable:
  - MODE path is 101 -> 000 -> 001 -> 111.
  - nMPSSEEN returns to 1 and no other enable is asserted.
  - PWROK blinks with period 8.
- In MPSSE_RUN, drive PWRSTAT 1->0 (pair 01 -> ERR_MB), then MRST -> 0 (pair 00):
  - Ends in EMU_RUN.
  - The checker confirms no overlap of nMPSSEEN = 0 with the emu enables, and at least 4 all-disabled cycles between them.
- In EMU_RUN, pulse MRST high for 5 cycles -> no state change. Hold high for 12 cycles -> MODE goes to 000 and all enables = 1.
- Assert nRST mid EMU_SETTLE (count = 2) -> outputs = 1 and MODE = 000 immediately; after release the full debounce and settle sequence repeats.
